// File: rtl/ttt_auto_player.sv
// ttt_auto_player: automatic tic-tac-toe move generator for one player.
// Waits for my_turn, picks a cell, pulses the matching button line, then waits for the
// controller to light that cell's LED. Optional macro TTT_AUTO_STRATEGY_EN enables the
// win / block / centre / corner / edge strategy; without it the lowest-index empty cell is played.
module ttt_auto_player #(
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [8:0] i_led,
    input  logic       i_my_turn,
    input  logic       i_new_game,
    output logic [8:0] o_btn,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    typedef enum logic [2:0] {StIdle, StThink, StPress, StWaitAck, StDone} state_e;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] r_rst_sync;
    logic       w_rst_n;
    state_e     r_state;
    state_e     w_state_next;
    logic [8:0] r_own;
    logic [8:0] w_own_next;
    logic [3:0] r_pick;
    logic [3:0] w_pick_next;
    logic [3:0] w_pick;
    logic [3:0] r_hold;
    logic [3:0] w_hold_next;
    logic [7:0] r_tmo;
    logic [7:0] w_tmo_next;
    logic       r_err;
    logic       w_err_next;
    logic [8:0] w_empty;
    logic       w_board_full;
    logic       w_ack;

    // Reset synchroniser: asserts asynchronously, releases on the second clock edge
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n      = r_rst_sync[1];
    assign w_empty      = ~i_led;
    assign w_board_full = (i_led == 9'h1FF);
    assign w_ack        = i_led[r_pick];

`ifdef TTT_AUTO_STRATEGY_EN
    logic [8:0] w_opp;
    logic [4:0] w_win;
    logic [4:0] w_block;

    assign w_opp = i_led & ~r_own;

    // Cells of each line, in scan order; packed as {a, b, c}
    function automatic logic [11:0] f_line(input logic [2:0] idx);
        logic [11:0] cells;
        case (idx)
            3'd0:    cells = {4'd0, 4'd1, 4'd2};
            3'd1:    cells = {4'd3, 4'd4, 4'd5};
            3'd2:    cells = {4'd6, 4'd7, 4'd8};
            3'd3:    cells = {4'd0, 4'd3, 4'd6};
            3'd4:    cells = {4'd1, 4'd4, 4'd7};
            3'd5:    cells = {4'd2, 4'd5, 4'd8};
            3'd6:    cells = {4'd0, 4'd4, 4'd8};
            default: cells = {4'd2, 4'd4, 4'd6};
        endcase
        return cells;
    endfunction

    function automatic logic [1:0] f_cnt3(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

    // Returns {found, cell}: first line with two 'side' cells and one empty cell.
    // Scanned last-to-first so the earliest qualifying line overwrites the rest.
    function automatic logic [4:0] f_scan(input logic [8:0] side, input logic [8:0] empty);
        logic [4:0]  res;
        logic [11:0] cells;
        logic [3:0]  ca;
        logic [3:0]  cb;
        logic [3:0]  cc;
        res = 5'd0;
        for (int l = 7; l >= 0; l--) begin
            cells = f_line(3'(l));
            ca    = cells[11:8];
            cb    = cells[7:4];
            cc    = cells[3:0];
            if (f_cnt3(side[ca], side[cb], side[cc]) == 2'd2 &&
                f_cnt3(empty[ca], empty[cb], empty[cc]) == 2'd1) begin
                res = {1'b1, empty[ca] ? ca : (empty[cb] ? cb : cc)};
            end
        end
        return res;
    endfunction

    assign w_win   = f_scan(r_own, w_empty);
    assign w_block = f_scan(w_opp, w_empty);

    // Strategy pick: lowest priority assigned first, higher priorities overwrite
    always_comb begin
        w_pick = 4'd0;
        if (w_empty[7]) w_pick = 4'd7;
        if (w_empty[5]) w_pick = 4'd5;
        if (w_empty[3]) w_pick = 4'd3;
        if (w_empty[1]) w_pick = 4'd1;
        if (w_empty[8]) w_pick = 4'd8;
        if (w_empty[6]) w_pick = 4'd6;
        if (w_empty[2]) w_pick = 4'd2;
        if (w_empty[0]) w_pick = 4'd0;
        if (w_empty[4]) w_pick = 4'd4;
        if (w_block[4]) w_pick = w_block[3:0];
        if (w_win[4])   w_pick = w_win[3:0];
    end
`else
    // Own-cell map only steers the strategy pick; kept so both builds behave alike otherwise
    logic w_unused_own;
    assign w_unused_own = ^r_own;

    // Simple pick: lowest-index empty cell
    always_comb begin
        w_pick = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (w_empty[4'(i)]) w_pick = 4'(i);
        end
    end
`endif

    // FSM state register
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; new_game overrides every transition
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (i_my_turn) w_state_next = StThink;
            StThink:   w_state_next = w_board_full ? StIdle : StPress;
            StPress:   if (r_hold == HOLD_LAST) w_state_next = StWaitAck;
            StWaitAck: begin
                if (w_ack) begin
                    w_state_next = StDone;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_next = StIdle;
                end
            end
            StDone:    w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
        if (i_new_game) w_state_next = StIdle;
    end

    // FSM outputs; button released at once on new_game
    always_comb begin
        o_btn = 9'd0;
        if (r_state == StPress && !i_new_game) o_btn = 9'd1 << r_pick;
        o_busy = (r_state != StIdle);
        o_done = (r_state == StDone);
        o_err  = r_err;
    end

    // Datapath next-state: pick capture, saturating counters, own map, error pulse
    always_comb begin
        w_own_next  = r_own;
        w_pick_next = r_pick;
        w_hold_next = r_hold;
        w_tmo_next  = r_tmo;
        w_err_next  = 1'b0;
        case (r_state)
            StThink: begin
                w_pick_next = w_pick;
                w_hold_next = 4'd0;
                w_tmo_next  = 8'd0;
                w_err_next  = w_board_full;
            end
            StPress: begin
                if (r_hold != 4'hF) w_hold_next = r_hold + 4'd1;
            end
            StWaitAck: begin
                if (w_ack) begin
                    w_own_next = r_own | (9'd1 << r_pick);
                end else begin
                    if (r_tmo != 8'hFF) w_tmo_next = r_tmo + 8'd1;
                    w_err_next = (r_tmo == TMO_LAST);
                end
            end
            default: ;
        endcase
        if (i_new_game) begin
            w_own_next = 9'd0;
            w_err_next = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_own  <= 9'd0;
            r_pick <= 4'd0;
            r_hold <= 4'd0;
            r_tmo  <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            r_own  <= w_own_next;
            r_pick <= w_pick_next;
            r_hold <= w_hold_next;
            r_tmo  <= w_tmo_next;
            r_err  <= w_err_next;
        end
    end

endmodule

// File: tb/tb_ttt_auto_player.sv
// Testbench for ttt_auto_player: directed vector table, hand-written corner sequences and
// randomized turns checked against a mask-based reference model of the pick rules.
// Follows the DUT build: define TTT_AUTO_STRATEGY_EN for both or neither.
module tb_ttt_auto_player;

    localparam int HOLD = 4;
    localparam int TMO  = 255;

    localparam int LINES [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                                    '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};
    localparam int PREF [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

    typedef struct {
        logic [8:0] own;
        logic [8:0] led;
        int         pick_strat;
        int         pick_dflt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] led;
    logic       my_turn;
    logic       new_game;
    logic [8:0] btn;
    logic       busy;
    logic       done;
    logic       err;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] m_own = 9'd0;
    vec_t       vecs [10];

    ttt_auto_player #(
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_led      (led),
        .i_my_turn  (my_turn),
        .i_new_game (new_game),
        .o_btn      (btn),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference pick straight from the game rules, using cell masks
    function automatic int model_pick(input logic [8:0] own, input logic [8:0] board);
        logic [8:0] empty;
        logic [8:0] side;
        logic [8:0] mask;
        empty = ~board;
`ifdef TTT_AUTO_STRATEGY_EN
        for (int pass = 0; pass < 2; pass++) begin
            side = (pass == 0) ? own : (board & ~own);
            for (int l = 0; l < 8; l++) begin
                mask = 9'd0;
                for (int c = 0; c < 3; c++) mask[LINES[l][c]] = 1'b1;
                if ($countones(side & mask) == 2 && $countones(empty & mask) == 1)
                    return $clog2(empty & mask);
            end
        end
        for (int k = 0; k < 9; k++) if (empty[PREF[k]]) return PREF[k];
`else
        side = 9'd0;
        mask = 9'd0;
        for (int i = 0; i < 9; i++) if (empty[i]) return i;
`endif
        return 0;
    endfunction

    // One full turn from IDLE: think, press for HOLD cycles, then ack or let it time out
    task automatic do_move(input string tag, input logic [8:0] board, input int exp_pick,
                           input bit ack, input int delay);
        logic [8:0] exp_btn;
        exp_btn = 9'd1 << exp_pick;
        led     = board;
        my_turn = 1'b1;
        tick();
        check({tag, " think busy"}, busy, 1);
        my_turn = 1'b0;
        tick();
        if (board == 9'h1FF) begin
            check({tag, " full err"}, err, 1);
            check({tag, " full btn"}, btn, 0);
            check({tag, " full busy"}, busy, 0);
            tick();
            check({tag, " full err drop"}, err, 0);
            return;
        end
        for (int i = 0; i < HOLD; i++) begin
            check({tag, " press btn"}, btn, exp_btn);
            tick();
        end
        check({tag, " release btn"}, btn, 0);
        check({tag, " wait busy"}, busy, 1);
        if (ack) begin
            for (int d = 0; d < delay; d++) tick();
            led = board | exp_btn;
            tick();
            m_own = m_own | exp_btn;
            check({tag, " done"}, done, 1);
            check({tag, " own"}, dut.r_own, m_own);
            tick();
            check({tag, " done drop"}, done, 0);
            check({tag, " idle"}, busy, 0);
        end else begin
            for (int k = 1; k < TMO; k++) tick();
            check({tag, " tmo early err"}, err, 0);
            check({tag, " tmo still busy"}, busy, 1);
            tick();
            check({tag, " tmo err"}, err, 1);
            check({tag, " tmo idle"}, busy, 0);
            check({tag, " tmo own"}, dut.r_own, m_own);
            tick();
            check({tag, " tmo err drop"}, err, 0);
        end
    endtask

    // Clear the game, then build an own map by playing single-empty-cell boards
    task automatic make_own(input logic [8:0] target);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        m_own    = 9'd0;
        for (int b = 0; b < 9; b++) begin
            if (target[b]) do_move("setup", 9'h1FF & ~(9'd1 << b), b, 1'b1, 0);
        end
    endtask

    // Enter PRESS and stop on its second cycle
    task automatic start_press(input logic [8:0] board);
        led     = board;
        my_turn = 1'b1;
        tick();
        my_turn = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int exp;
        vecs[0] = '{9'h000, 9'h000, 4, 0};
        vecs[1] = '{9'h003, 9'h00B, 2, 2};
        vecs[2] = '{9'h010, 9'h058, 0, 0};
        vecs[3] = '{9'h000, 9'h013, 2, 2};
        vecs[4] = '{9'h000, 9'h001, 4, 1};
        vecs[5] = '{9'h010, 9'h011, 2, 1};
        vecs[6] = '{9'h000, 9'h180, 6, 0};
        vecs[7] = '{9'h0C0, 9'h0C3, 8, 2};
        vecs[8] = '{9'h101, 9'h155, 1, 1};
        vecs[9] = '{9'h000, 9'h010, 0, 0};

        rst_n    = 1'b0;
        led      = 9'd0;
        my_turn  = 1'b0;
        new_game = 1'b0;
        #1;
        check("reset btn", btn, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset own", dut.r_own, 0);
        check("reset pick", dut.r_pick, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("idle without turn", busy, 0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            make_own(vecs[i].own);
            check("table own setup", dut.r_own, vecs[i].own);
`ifdef TTT_AUTO_STRATEGY_EN
            exp = vecs[i].pick_strat;
`else
            exp = vecs[i].pick_dflt;
`endif
            do_move("table", vecs[i].led, exp, 1'b1, i % 3);
        end

        // Full board: no press, error pulse
        do_move("full", 9'h1FF, 0, 1'b0, 0);

        // Acknowledge timeout
        do_move("timeout", m_own, model_pick(m_own, m_own), 1'b0, 0);

        // new_game mid-press: button drops, idle next cycle, own cleared
        start_press(m_own);
        check("ng pressing", busy, 1);
        new_game = 1'b1;
        #1;
        check("ng btn forced", btn, 0);
        tick();
        new_game = 1'b0;
        m_own    = 9'd0;
        check("ng idle", busy, 0);
        check("ng own", dut.r_own, 0);
        check("ng btn", btn, 0);

        // Reset mid-press: button drops without a clock edge
        do_move("pre rst", 9'h000, model_pick(9'd0, 9'h000), 1'b1, 0);
        start_press(m_own);
        check("rst pressing", btn, 9'd1 << model_pick(m_own, m_own));
        rst_n = 1'b0;
        #1;
        check("rst btn async", btn, 0);
        check("rst busy async", busy, 0);
        check("rst own async", dut.r_own, 0);
        m_own = 9'd0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("rst release idle", busy, 0);

        // Randomized turns against the model
        for (int it = 0; it < 40; it++) begin
            logic [8:0] rl;
            int         r;
            if (it % 6 == 5) begin
                new_game = 1'b1;
                tick();
                new_game = 1'b0;
                m_own    = 9'd0;
                check("rand new_game own", dut.r_own, 0);
            end
            r  = $urandom_range(0, 9);
            rl = m_own | (9'($urandom) & ~m_own);
            if (r == 0) rl = 9'h1FF;
            do_move("rand", rl, model_pick(m_own, rl), (r != 1), $urandom_range(0, 6));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
